// File: rtl/regfile_vec_wr_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regvec_pkg: vector register-file geometry and shared types.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package regvec_pkg;

  localparam int LANES       = 3;
  localparam int LANE_W      = 18;
  localparam int ADDR_W      = 4;
  localparam int NUM_GPR     = 12;
  localparam int KERNEL_BASE = NUM_GPR;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
  typedef logic [ADDR_W-1:0]            reg_addr_t;

  function automatic logic is_kernel_addr(reg_addr_t addr);
    return addr >= reg_addr_t'(KERNEL_BASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_vec_wr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_vec_wr_arbiter_if: write-request bus from the producers.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface regfile_vec_wr_arbiter_if
  import regvec_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  logic      [NUM_REQ-1:0] req_valid;
  reg_addr_t [NUM_REQ-1:0] req_addr;
  vec_t      [NUM_REQ-1:0] req_data;
  logic      [NUM_REQ-1:0] req_ready;

  modport master (output req_valid, output req_addr, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/regfile_vec_wr_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin grant, owns priority pointer.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic               en,
  input  wire logic               advance,
  output logic      [NUM_REQ-1:0] grant,
  output logic      [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] r_ptr;
  int unsigned      w_pos;
  logic             w_found;

  // Scan from the pointer, wrapping, and take the first active request.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(r_ptr) + k) % NUM_REQ;
      if (en && !w_found && req[w_pos]) begin
        grant[w_pos] = 1'b1;
        idx          = IDX_W'(w_pos);
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      if (idx == IDX_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                            r_ptr <= idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_vec_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_vec_wr_arbiter: shares the vector RF write port, blocks    |
// | kernel-register writes. Rev 1.0                                    |
// +--------------------------------------------------------------------+
module regfile_vec_wr_arbiter
  import regvec_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     freeze,
  regfile_vec_wr_arbiter_if.slave       bus,
  output logic                          we3,
  output reg_addr_t                     ra3,
  output vec_t                          wd3,
  output logic      [SRC_W-1:0]         wr_src,
  output logic                          err_illegal,
  output logic      [7:0]               illegal_cnt
);

  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_en;
  logic               w_xfer;
  logic               w_illegal;
  reg_addr_t          w_addr;
  vec_t               w_data;

  // Gating by reset keeps ready low while the block is held in reset.
  assign w_en = !freeze && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .en      (w_en),
    .advance (w_xfer),
    .grant   (w_grant),
    .idx     (w_idx)
  );

  assign bus.req_ready = w_grant;
  assign w_xfer        = |w_grant;
  assign w_addr        = bus.req_addr[w_idx];
  assign w_data        = bus.req_data[w_idx];
  assign w_illegal     = is_kernel_addr(w_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3         <= 1'b0;
      ra3         <= '0;
      wd3         <= '0;
      wr_src      <= '0;
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      we3 <= 1'b0;
      if (w_xfer) begin
        if (w_illegal) begin
          // Accepted so the producer is released, but never reaches the RF.
          err_illegal <= 1'b1;
          if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
        end else begin
          we3    <= 1'b1;
          ra3    <= w_addr;
          wd3    <= w_data;
          wr_src <= w_idx;
        end
      end
    end
  end

endmodule
`default_nettype wire
